uart_frame_ctrl: RTL and testbench

Receive-side frame controller that sits directly behind one `uart_rx` instance on each module link. It synchronises the receiver's byte-complete flag into the system clock domain and hunts for a start-of-frame byte. It then assembles a fixed-length payload, checks it against a trailing XOR checksum, and enforces an inter-byte timeout. Upstream logic sees only whole, validated frames (`frame_valid`) or a classified error pulse (`frame_error`, `err_code`).

---
 rtl/uart_frame_ctrl_pkg.sv | 26 ++
 rtl/uart_frame_ctrl_sync_rise_det.sv | 33 +++
 rtl/uart_frame_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_ctrl_pkg.sv
// Shared definitions for the UART receive frame controller: default start-of-frame
// byte, error classification codes, FSM states and a saturating counter helper.
`timescale 1ns/1ps

package uart_frame_ctrl_pkg;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_PARITY  = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_e;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_frame_ctrl_sync_rise_det.sv
// Two-flop synchroniser followed by a rising-edge detector. Flops reset to
// RESET_VAL so that a level already high at reset release does not fire.
`timescale 1ns/1ps

module sync_rise_det #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // NOTE: non-blocking assignments make each flop take its predecessor's old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= RESET_VAL;
            r_s2 <= RESET_VAL;
            r_s3 <= RESET_VAL;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/uart_frame_ctrl.sv
// Receive-side frame controller behind a uart_rx: hunts for SOF, assembles a
// fixed-length payload, verifies the trailing XOR checksum and enforces a timeout.
`timescale 1ns/1ps

module uart_frame_ctrl
    import uart_frame_ctrl_pkg::*;
#(
    parameter int         NUM_BYTES      = 2,
    parameter logic [7:0] SOF            = SOF_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_done,
    input  logic [7:0]             data_received,
    input  logic                   parity_error,
    output logic [8*NUM_BYTES-1:0] frame_data,
    output logic                   frame_valid,
    output logic                   frame_error,
    output logic [1:0]             err_code,
    output logic [7:0]             err_count,
    output logic                   busy
);

    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_HIT  = TMO_W'(TIMEOUT_CYCLES - 2);

    logic                   w_byte_stb;
    logic                   r_byte_vld;
    logic [7:0]             r_byte;
    logic                   r_byte_perr;
    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [IDX_W-1:0]       r_idx;
    logic [7:0]             r_xor;
    logic [8*NUM_BYTES-1:0] r_payload;
    logic [8*NUM_BYTES-1:0] r_frame_data;
    logic [TMO_W-1:0]       r_tmo;
    logic                   r_frame_valid;
    logic                   r_frame_error;
    err_code_e              r_err_code;
    logic [7:0]             r_err_count;
    logic                   w_tmo_hit;
    logic                   w_sof;
    logic                   w_store;
    logic                   w_frame_ok;
    logic                   w_err;
    err_code_e              w_err_code;

    sync_rise_det #(.RESET_VAL(1'b1)) u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (rx_done),
        .o_rise  (w_byte_stb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte_vld  <= 1'b0;
            r_byte      <= 8'h00;
            r_byte_perr <= 1'b0;
        end else begin
            r_byte_vld <= w_byte_stb;
            if (w_byte_stb) begin
                r_byte      <= data_received;
                r_byte_perr <= parity_error;
            end
        end
    end

    // Counting also on the SOF decision keeps every gap, including the first, at exactly TIMEOUT_CYCLES.
    always_ff @(posedge clk) begin
        if (reset || w_byte_stb) begin
            r_tmo <= '0;
        end else if (r_state != ST_HUNT || w_sof) begin
            r_tmo <= r_tmo + 1'b1;
        end else begin
            r_tmo <= '0;
        end
    end

    assign w_tmo_hit = (r_state != ST_HUNT) && !w_byte_stb && (r_tmo == TMO_HIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_sof       = 1'b0;
        w_store     = 1'b0;
        w_frame_ok  = 1'b0;
        w_err       = 1'b0;
        w_err_code  = ERR_NONE;
        if (r_byte_vld) begin
            if (r_byte_perr) begin
                w_err       = 1'b1;
                w_err_code  = ERR_PARITY;
                w_state_nxt = ST_HUNT;
            end else begin
                case (r_state)
                    ST_HUNT: begin
                        if (r_byte == SOF) begin
                            w_sof       = 1'b1;
                            w_state_nxt = ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        w_store = 1'b1;
                        if (r_idx == LAST_IDX) begin
                            w_state_nxt = ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        w_state_nxt = ST_HUNT;
                        if (r_byte == r_xor) begin
                            w_frame_ok = 1'b1;
                        end else begin
                            w_err      = 1'b1;
                            w_err_code = ERR_CSUM;
                        end
                    end
                    default: w_state_nxt = ST_HUNT;
                endcase
            end
        end else if (w_tmo_hit) begin
            w_err       = 1'b1;
            w_err_code  = ERR_TIMEOUT;
            w_state_nxt = ST_HUNT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx         <= '0;
            r_xor         <= 8'h00;
            r_frame_data  <= '0;
            r_frame_valid <= 1'b0;
            r_frame_error <= 1'b0;
            r_err_code    <= ERR_NONE;
            r_err_count   <= 8'h00;
        end else begin
            r_frame_valid <= w_frame_ok;
            r_frame_error <= w_err;
            if (w_sof) begin
                r_idx <= '0;
                r_xor <= 8'h00;
            end else if (w_store) begin
                r_idx <= r_idx + 1'b1;
                r_xor <= r_xor ^ r_byte;
            end
            if (w_frame_ok) begin
                r_frame_data <= r_payload;
            end
            if (w_err) begin
                r_err_code  <= w_err_code;
                r_err_count <= sat_inc8(r_err_count);
            end
        end
    end

    // NOTE: payload storage has no reset; every slot is rewritten before it can reach frame_data.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_payload[r_idx*8 +: 8] <= r_byte;
        end
    end

    assign frame_data  = r_frame_data;
    assign frame_valid = r_frame_valid;
    assign frame_error = r_frame_error;
    assign err_code    = r_err_code;
    assign err_count   = r_err_count;
    assign busy        = (r_state != ST_HUNT);

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl: a frame-level protocol model predicts
// every output each cycle, and literal checks pin key scenario results.
`timescale 1ns/1ps

module tb_uart_frame_ctrl;

    localparam int         NB  = 2;
    localparam logic [7:0] SOF = 8'hA5;
    localparam int         T   = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_done = 1'b0;
    logic [7:0]  data_received = 8'h00;
    logic        parity_error = 1'b0;
    logic [15:0] frame_data;
    logic        frame_valid;
    logic        frame_error;
    logic [1:0]  err_code;
    logic [7:0]  err_count;
    logic        busy;

    uart_frame_ctrl #(
        .NUM_BYTES      (NB),
        .SOF            (SOF),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_done       (rx_done),
        .data_received (data_received),
        .parity_error  (parity_error),
        .frame_data    (frame_data),
        .frame_valid   (frame_valid),
        .frame_error   (frame_error),
        .err_code      (err_code),
        .err_count     (err_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_err_pulses = 0;
    int last_drive = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    endtask

    // ---------------- frame-level model ----------------
    typedef struct { int sc; logic [7:0] d; bit pe; } byte_t;
    typedef struct { bit vld; bit err; bit bsy; logic [1:0] code; logic [7:0] cnt; logic [15:0] data; } ev_t;

    byte_t      pend[$];
    ev_t        ev[int];
    bit         m_rst = 1'b1;
    bit         m_in_frame = 1'b0;
    logic [7:0] m_buf[$];
    int         m_due = 0;
    logic [1:0] m_code = 0;
    logic [7:0] m_cnt = 0;
    logic [15:0] m_data = 0;
    bit         e_busy = 0;
    logic [1:0] e_code = 0;
    logic [7:0] e_cnt = 0;
    logic [15:0] e_data = 0;

    function automatic void push_ev(int c, bit v, bit e, bit b);
        ev[c] = '{vld: v, err: e, bsy: b, code: m_code, cnt: m_cnt, data: m_data};
    endfunction

    function automatic void model_error(logic [1:0] code);
        m_code = code;
        if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
    endfunction

    function automatic void model_byte(logic [7:0] d, bit pe, int sc);
        logic [7:0] x;
        if (pe) begin
            model_error(2'd1);
            m_in_frame = 1'b0;
            push_ev(sc + 2, 1'b0, 1'b1, 1'b0);
            return;
        end
        if (!m_in_frame) begin
            if (d == SOF) begin
                m_in_frame = 1'b1;
                m_buf.delete();
                m_due = sc + T;
                push_ev(sc + 2, 1'b0, 1'b0, 1'b1);
            end
            return;
        end
        m_due = sc + T;
        if (m_buf.size() < NB) begin
            m_buf.push_back(d);
            return;
        end
        x = 8'h00;
        foreach (m_buf[i]) x = x ^ m_buf[i];
        m_in_frame = 1'b0;
        if (d == x) begin
            for (int i = 0; i < NB; i++) m_data[8*i +: 8] = m_buf[i];
            push_ev(sc + 2, 1'b1, 1'b0, 1'b0);
        end else begin
            model_error(2'd2);
            push_ev(sc + 2, 1'b0, 1'b1, 1'b0);
        end
    endfunction

    function automatic void model_clear();
        pend.delete();
        ev.delete();
        m_buf.delete();
        m_in_frame = 1'b0;
        m_code = 0; m_cnt = 0; m_data = 0;
        e_busy = 0; e_code = 0; e_cnt = 0; e_data = 0;
        m_rst = 1'b0;
    endfunction

    always @(negedge clk) begin
        byte_t b;
        ev_t   e;
        bit    xv;
        bit    xe;
        if (frame_error) n_err_pulses++;
        if (!m_rst) begin
            if (m_in_frame && cyc == m_due) begin
                model_error(2'd3);
                m_in_frame = 1'b0;
                push_ev(cyc, 1'b0, 1'b1, 1'b0);
            end
            while (pend.size() > 0 && pend[0].sc == cyc) begin
                b = pend.pop_front();
                model_byte(b.d, b.pe, b.sc);
            end
            xv = 1'b0;
            xe = 1'b0;
            if (ev.exists(cyc)) begin
                e = ev[cyc];
                ev.delete(cyc);
                xv = e.vld; xe = e.err; e_busy = e.bsy;
                e_code = e.code; e_cnt = e.cnt; e_data = e.data;
            end
            check("outputs{valid,error,busy,code,count,data}",
                  {3'b000, frame_valid, frame_error, busy, err_code, err_count, frame_data},
                  {3'b000, xv, xe, e_busy, e_code, e_cnt, e_data});
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] d, input bit pe);
        byte_t b;
        @(posedge clk); #1;
        data_received = d;
        parity_error  = pe;
        rx_done       = 1'b1;
        b.sc = cyc + 2; b.d = d; b.pe = pe;
        pend.push_back(b);
        last_drive = cyc;
        repeat (4) @(posedge clk);
        #1 rx_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        send_byte(a, 1'b0);
        send_byte(b, 1'b0);
        send_byte(c, 1'b0);
        send_byte(d, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        m_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
        @(negedge clk);
        check("reset_state", {frame_valid, frame_error, busy, err_code, err_count, frame_data}, 32'd0);

        send4(8'hA5, 8'h12, 8'h34, 8'h26);
        check("good_data", frame_data, 32'h3412);
        check("good_count", err_count, 32'd0);

        send4(8'hA5, 8'h12, 8'h34, 8'h27);
        check("csum_code", err_code, 32'd2);
        check("csum_count", err_count, 32'd1);
        check("csum_data_kept", frame_data, 32'h3412);

        send_byte(8'hA5, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b1);
        check("parity_code", err_code, 32'd1);
        check("parity_count", err_count, 32'd2);
        check("parity_busy", busy, 32'd0);
        send4(8'hA5, 8'h56, 8'h78, 8'h2E);
        check("after_parity_data", frame_data, 32'h7856);

        send_byte(8'h00, 1'b1);
        check("hunt_parity_count", err_count, 32'd3);
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send4(8'hA5, 8'h12, 8'h34, 8'h26);
        check("noise_data", frame_data, 32'h3412);
        check("noise_count", err_count, 32'd3);

        send4(8'hA5, 8'hA5, 8'h00, 8'hA5);
        check("sof_as_data", frame_data, 32'h00A5);

        send_byte(8'hA5, 1'b0);
        send_byte(8'h12, 1'b0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_error) break;
        end
        check("timeout_latency", 32'(cyc - last_drive), 32'd66);
        check("timeout_code", err_code, 32'd3);
        check("timeout_count", err_count, 32'd4);

        send_byte(8'hA5, 1'b0);
        send_byte(8'h12, 1'b0);
        do_reset();
        @(negedge clk);
        check("midframe_reset", {frame_valid, frame_error, busy, err_code, err_count, frame_data}, 32'd0);
        send4(8'hA5, 8'h12, 8'h34, 8'h26);
        check("post_reset_frame", frame_data, 32'h3412);

        @(posedge clk); #1;
        reset = 1'b1;
        m_rst = 1'b1;
        @(posedge clk); #1;
        data_received = SOF;
        parity_error  = 1'b0;
        rx_done       = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
        repeat (8) @(posedge clk);
        #1;
        check("held_rx_done_busy", busy, 32'd0);
        check("held_rx_done_data", frame_data, 32'd0);
        rx_done = 1'b0;
        repeat (4) @(posedge clk);
        send4(8'hA5, 8'h56, 8'h78, 8'h2E);
        check("held_then_frame", frame_data, 32'h7856);

        n_err_pulses = 0;
        for (int f = 0; f < 260; f++) send4(8'hA5, 8'h12, 8'h34, 8'h27);
        check("sat_count", err_count, 32'd255);
        check("sat_pulses", n_err_pulses, 32'd260);
        check("sat_data_kept", frame_data, 32'h7856);

        repeat (10) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
